// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the matrix-multiply accelerator
// sequencing controller (acc_mm_ctrl) and its operand/result buffers.
//   acc_word_t   : one 32-bit datapath word, packed as four bytes
//   acc_state_e  : controller FSM states
//   SEL_*        : cfg_sel target encodings
//   ST_* / CTRL_*: status read and control write bit positions
package acc_pkg;

  typedef logic [3:0][7:0] acc_word_t;

  typedef enum logic [1:0] {
    ACC_IDLE    = 2'd0,
    ACC_SETTLE  = 2'd1,
    ACC_CAPTURE = 2'd2
  } acc_state_e;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_LAT_LSB = 4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_ERR  = 2;

endpackage

// File: rtl/acc_buf.sv
// acc_buf: DEPTH-word flop buffer.
//   clk, rst      : clock, synchronous active-high reset (clears all words)
//   wr_en/addr/data : single-word write port
//   cap_en/cap_data : whole-array load; wins over the single-word write
//   rd_addr/rd_data : asynchronous read mux
//   mem             : full-array output (drives the datapath)
module acc_buf
  import acc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  acc_word_t         wr_data,
  input  logic              cap_en,
  input  acc_word_t         cap_data [DEPTH],
  input  logic [ADDR_W-1:0] rd_addr,
  output acc_word_t         rd_data,
  output acc_word_t         mem [DEPTH]
);

  acc_word_t mem_q [DEPTH];
  acc_word_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (cap_en) begin
      mem_d = cap_data;
    end else if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign mem     = mem_q;

endmodule

// File: rtl/acc_mm_ctrl.sv
// acc_mm_ctrl: sequencing controller for the matrix-multiply datapath.
// Owns the A/B operand buffers and the C result buffer, exposes them through
// a single-beat register interface, and runs START -> SETTLE -> CAPTURE.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_req/we/sel/addr/wdata : request (sel 0=A, 1=B, 2=C ro, 3=ctrl/status)
//   cfg_gnt         : combinational grant (= cfg_req)
//   cfg_rvalid/rdata: response one cycle after the request
//   irq_done        : one-cycle completion pulse
//   dp_a, dp_b      : operand arrays to the datapath
//   dp_c            : result array from the datapath
// Optional feature macro: ACC_IRQ_EN (irq_done pulse logic; tied 0 otherwise).
module acc_mm_ctrl
  import acc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_req,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  acc_word_t         cfg_wdata,
  output logic              cfg_gnt,
  output logic              cfg_rvalid,
  output logic [31:0]       cfg_rdata,
  output logic              irq_done,
  output acc_word_t         dp_a [DEPTH],
  output acc_word_t         dp_b [DEPTH],
  input  acc_word_t         dp_c [DEPTH]
);

  acc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        busy, wr, rd, ctrl_wr, start, capture, err_set;
  logic        a_we, b_we;
  acc_word_t   a_rdata, b_rdata, c_rdata;
  logic [31:0] status;
  acc_word_t   zero_words [DEPTH];
  acc_word_t   unused_c_mem [DEPTH];
  logic        unused_wdata;

  assign zero_words   = '{default: '0};
  assign unused_wdata = ^cfg_wdata[3][7:0] ^ ^cfg_wdata[2][7:0] ^ ^cfg_wdata[1][7:0]
                      ^ ^cfg_wdata[0][7:3];

  assign cfg_gnt = cfg_req;
  assign busy    = (state_q != ACC_IDLE);
  assign wr      = cfg_req & cfg_we;
  assign rd      = cfg_req & ~cfg_we;
  assign ctrl_wr = wr & (cfg_sel == SEL_CTRL);
  assign start   = ctrl_wr & cfg_wdata[0][CTRL_START];

  // Operand writes are locked out while busy so dp_a/dp_b stay stable
  // for the whole settle/capture window.
  assign a_we = wr & (cfg_sel == SEL_A) & ~busy;
  assign b_we = wr & (cfg_sel == SEL_B) & ~busy;

  acc_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf_a (
    .clk(clk), .rst(rst), .wr_en(a_we), .wr_addr(cfg_addr), .wr_data(cfg_wdata),
    .cap_en(1'b0), .cap_data(zero_words), .rd_addr(cfg_addr), .rd_data(a_rdata),
    .mem(dp_a)
  );

  acc_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf_b (
    .clk(clk), .rst(rst), .wr_en(b_we), .wr_addr(cfg_addr), .wr_data(cfg_wdata),
    .cap_en(1'b0), .cap_data(zero_words), .rd_addr(cfg_addr), .rd_data(b_rdata),
    .mem(dp_b)
  );

  acc_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf_c (
    .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr('0), .wr_data('0),
    .cap_en(capture), .cap_data(dp_c), .rd_addr(cfg_addr), .rd_data(c_rdata),
    .mem(unused_c_mem)
  );

  // The counter is loaded with DP_LAT-1 so that SETTLE lasts exactly DP_LAT
  // cycles before the capture cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ACC_IDLE: begin
        if (start) begin
          state_d = ACC_SETTLE;
          cnt_d   = 4'(DP_LAT - 1);
        end
      end
      ACC_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ACC_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACC_CAPTURE: begin
        capture = 1'b1;
        state_d = ACC_IDLE;
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  // Sticky flags: the capture set beats a same-cycle CLR_DONE, and any error
  // source beats a same-cycle error clear.
  always_comb begin
    err_set = (wr & ((cfg_sel == SEL_A) | (cfg_sel == SEL_B)) & busy)
            | (start & busy)
            | (wr & (cfg_sel == SEL_C));

    done_d = done_q;
    if (capture) begin
      done_d = 1'b1;
    end else if ((start & ~busy) | (ctrl_wr & cfg_wdata[0][CTRL_CLR_DONE])) begin
      done_d = 1'b0;
    end

    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (ctrl_wr & cfg_wdata[0][CTRL_CLR_ERR]) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    status                          = '0;
    status[ST_BUSY]                 = busy;
    status[ST_DONE]                 = done_q;
    status[ST_ERR]                  = err_q;
    status[ST_LAT_LSB+3:ST_LAT_LSB] = 4'(DP_LAT);

    rvalid_d = cfg_req;
    rdata_d  = '0;
    if (rd) begin
      case (cfg_sel)
        SEL_A:   rdata_d = a_rdata;
        SEL_B:   rdata_d = b_rdata;
        SEL_C:   rdata_d = c_rdata;
        default: rdata_d = status;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACC_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rdata_q;

`ifdef ACC_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_done = irq_q;
`else
  assign irq_done = 1'b0;
`endif

endmodule

// File: tb/tb_acc_mm_ctrl.sv
// tb_acc_mm_ctrl: self-checking bench for acc_mm_ctrl (DEPTH 256, DP_LAT 2).
// The datapath is modelled as an element-wise product C[i] = A[i] * B[i].
module tb_acc_mm_ctrl;
  import acc_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int DP_LAT = 2;
  localparam logic [31:0] LAT_FIELD = 32'(DP_LAT) << 4;

  logic        clk;
  logic        rst;
  logic        cfg_req;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_addr;
  acc_word_t   cfg_wdata;
  logic        cfg_gnt;
  logic        cfg_rvalid;
  logic [31:0] cfg_rdata;
  logic        irq_done;
  acc_word_t   dp_a [DEPTH];
  acc_word_t   dp_b [DEPTH];
  acc_word_t   dp_c [DEPTH];

  int n_compared;
  int n_mismatched;
  int cyc;
  int irq_cnt;
  int irq_cyc;
  int start_cyc;
  int irq_before;
  logic        got_rvalid;
  logic [31:0] got_rdata;

  acc_mm_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid),
    .cfg_rdata(cfg_rdata), .irq_done(irq_done),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dp_c[i] = 32'(dp_a[i]) * 32'(dp_b[i]);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Interrupt monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (irq_done === 1'b1) begin
      irq_cnt <= irq_cnt + 1;
      irq_cyc <= cyc;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request beat; returns the response seen one cycle later.
  task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [7:0] addr,
                               input logic [31:0] wdata);
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    @(posedge clk);
    #1;
    got_rvalid = cfg_rvalid;
    got_rdata  = cfg_rdata;
    cfg_req    = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readCheck(input string name, input logic [1:0] sel, input logic [7:0] addr,
                           input logic [31:0] exp);
    applyStimulus(1'b0, sel, addr, 32'h0);
    checkOutput({name, "_rvalid"}, 32'(got_rvalid), 32'h1);
    checkOutput(name, got_rdata, exp);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    irq_cnt      = 0;
    irq_cyc      = -1;
    rst          = 1'b1;
    cfg_req      = 1'b0;
    cfg_we       = 1'b0;
    cfg_sel      = 2'd0;
    cfg_addr     = '0;
    cfg_wdata    = '0;

    tbl[0]  = '{1'b1, SEL_A, 8'd0, 32'd1, 32'd0};
    tbl[1]  = '{1'b1, SEL_A, 8'd1, 32'd2, 32'd0};
    tbl[2]  = '{1'b1, SEL_A, 8'd2, 32'd3, 32'd0};
    tbl[3]  = '{1'b1, SEL_A, 8'd3, 32'd4, 32'd0};
    tbl[4]  = '{1'b1, SEL_B, 8'd0, 32'd1, 32'd0};
    tbl[5]  = '{1'b1, SEL_B, 8'd1, 32'd1, 32'd0};
    tbl[6]  = '{1'b1, SEL_B, 8'd2, 32'd1, 32'd0};
    tbl[7]  = '{1'b1, SEL_B, 8'd3, 32'd1, 32'd0};
    tbl[8]  = '{1'b1, SEL_A, 8'd5, 32'd7, 32'd0};
    tbl[9]  = '{1'b1, SEL_B, 8'd5, 32'd3, 32'd0};
    tbl[10] = '{1'b0, SEL_A, 8'd2, 32'd0, 32'd3};
    tbl[11] = '{1'b0, SEL_CTRL, 8'd0, 32'd0, LAT_FIELD};

    // Reset state
    idle(3);
    rst = 1'b0;
    checkOutput("rst_rvalid", 32'(cfg_rvalid), 32'h0);
    checkOutput("rst_rdata", cfg_rdata, 32'h0);
    checkOutput("rst_irq", 32'(irq_done), 32'h0);
    checkOutput("rst_dp_a0", dp_a[0], 32'h0);
    checkOutput("rst_dp_b7", dp_b[7], 32'h0);
    cfg_req = 1'b1;
    #1;
    checkOutput("gnt_comb", 32'(cfg_gnt), 32'h1);
    cfg_req = 1'b0;
    #1;
    checkOutput("gnt_idle", 32'(cfg_gnt), 32'h0);
    readCheck("rst_c0", SEL_C, 8'd0, 32'h0);

    // Table-driven register accesses (back-to-back)
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].wdata);
      checkOutput($sformatf("tbl%0d_rvalid", i), 32'(got_rvalid), 32'h1);
      checkOutput($sformatf("tbl%0d_rdata", i), got_rdata, tbl[i].exp);
    end
    checkOutput("dp_a3", dp_a[3], 32'd4);
    checkOutput("dp_b5", dp_b[5], 32'd3);

    // Write to A is visible on dp_a the next cycle
    applyStimulus(1'b1, SEL_A, 8'd9, 32'h0000_0055);
    checkOutput("dp_a9_next", dp_a[9], 32'h55);

    // Basic multiply: irq at t+4, done set, C = A (B identity)
    irq_before = irq_cnt;
    start_cyc  = cyc;
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h1);
    readCheck("basic_busy", SEL_CTRL, 8'd0, LAT_FIELD | 32'h1);
    idle(2);
`ifdef ACC_IRQ_EN
    checkOutput("basic_irq_t4", 32'(irq_done), 32'h1);
`else
    checkOutput("basic_irq_off", 32'(irq_done), 32'h0);
`endif
    readCheck("basic_done", SEL_CTRL, 8'd0, LAT_FIELD | 32'h2);
    for (int i = 0; i < 4; i++) begin
      readCheck($sformatf("basic_c%0d", i), SEL_C, 8'(i), 32'(i + 1));
    end
`ifdef ACC_IRQ_EN
    checkOutput("basic_irq_count", 32'(irq_cnt - irq_before), 32'd1);
    checkOutput("basic_irq_cycle", 32'(irq_cyc - start_cyc), 32'd4);
`else
    checkOutput("basic_irq_count", 32'(irq_cnt - irq_before), 32'd0);
`endif

    // Busy lockout
    irq_before = irq_cnt;
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h1);
    applyStimulus(1'b1, SEL_A, 8'd0, 32'hFF);
    checkOutput("lock_wr_rvalid", 32'(got_rvalid), 32'h1);
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h1);
    checkOutput("lock_start_rvalid", 32'(got_rvalid), 32'h1);
    readCheck("lock_status_cap", SEL_CTRL, 8'd0, LAT_FIELD | 32'h5);
    readCheck("lock_status_end", SEL_CTRL, 8'd0, LAT_FIELD | 32'h6);
    checkOutput("lock_dp_a0", dp_a[0], 32'd1);
    idle(4);
`ifdef ACC_IRQ_EN
    checkOutput("lock_irq_count", 32'(irq_cnt - irq_before), 32'd1);
`else
    checkOutput("lock_irq_count", 32'(irq_cnt - irq_before), 32'd0);
`endif
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h4);
    readCheck("err_clear", SEL_CTRL, 8'd0, LAT_FIELD | 32'h2);

    // Done set/clear race
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h1);
    idle(2);
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h2);
    readCheck("race_set_wins", SEL_CTRL, 8'd0, LAT_FIELD | 32'h2);
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h2);
    readCheck("race_clr", SEL_CTRL, 8'd0, LAT_FIELD);
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h2);
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h3);
    readCheck("start_clr", SEL_CTRL, 8'd0, LAT_FIELD | 32'h1);
    idle(4);
    readCheck("start_clr_end", SEL_CTRL, 8'd0, LAT_FIELD | 32'h2);

    // Response timing: C write, C read, status read back-to-back
    applyStimulus(1'b1, SEL_C, 8'd5, 32'hDEAD);
    checkOutput("resp0_rvalid", 32'(got_rvalid), 32'h1);
    checkOutput("resp0_rdata", got_rdata, 32'h0);
    applyStimulus(1'b0, SEL_C, 8'd5, 32'h0);
    checkOutput("resp1_rvalid", 32'(got_rvalid), 32'h1);
    checkOutput("resp1_rdata", got_rdata, 32'd21);
    applyStimulus(1'b0, SEL_CTRL, 8'd0, 32'h0);
    checkOutput("resp2_rvalid", 32'(got_rvalid), 32'h1);
    checkOutput("resp2_rdata", got_rdata, LAT_FIELD | 32'h6);
    idle(1);
    checkOutput("resp3_rvalid", 32'(cfg_rvalid), 32'h0);

    // Reset mid-SETTLE
    irq_before = irq_cnt;
    applyStimulus(1'b1, SEL_CTRL, 8'd0, 32'h1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("midrst_irq", 32'(irq_done), 32'h0);
    readCheck("midrst_status", SEL_CTRL, 8'd0, LAT_FIELD);
    readCheck("midrst_c0", SEL_C, 8'd0, 32'h0);
    checkOutput("midrst_dp_a0", dp_a[0], 32'h0);
    idle(DP_LAT + 3);
    checkOutput("midrst_no_irq", 32'(irq_cnt - irq_before), 32'd0);
    readCheck("midrst_idle", SEL_CTRL, 8'd0, LAT_FIELD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
